// File: rtl/matrix_multiply_32_pkg.sv
// Shared constants and element/row types for the 32x32 streaming matrix-multiply engine.
package matmul32_pkg;

  localparam int N  = 32;
  localparam int W  = 32;
  localparam int IW = 5;

  localparam logic [IW-1:0] LAST_IDX = 5'd31;

  typedef logic [W-1:0] elem_t;
  typedef elem_t [N-1:0] row_t;

endpackage

// File: rtl/matrix_multiply_32_if.sv
// Operand/result bundle of matrix_multiply_32; the engine side is the slave modport.
interface matrix_multiply_32_if;
  import matmul32_pkg::*;

  logic          select_line_in;
  row_t          A_wire;
  row_t          B_wire;
  logic [IW-1:0] index_A;
  logic [IW-1:0] index_B;
  row_t          out;
  logic [IW-1:0] out_address;
  logic          select_line_out;
  logic          write_data;

  modport master (
    output select_line_in, A_wire, B_wire, index_A, index_B,
    input  out, out_address, select_line_out, write_data
  );

  modport slave (
    input  select_line_in, A_wire, B_wire, index_A, index_B,
    output out, out_address, select_line_out, write_data
  );

endinterface

// File: rtl/matrix_multiply_32_dot32.sv
// 32-lane truncating multiplier and wrap-around adder tree, split so a register can sit between them.
module dot32
  import matmul32_pkg::*;
(
  input  row_t  a,
  input  row_t  b,
  output row_t  prod,
  input  row_t  sum_in,
  output elem_t dot
);

  // Lane products keep only the low W bits, so signed and unsigned operands agree.
  always_comb begin
    prod = '0;
    for (int e = 0; e < N; e++) begin
      prod[e] = a[e] * b[e];
    end
  end

  // Pairwise reduction; each level halves the live lanes in place.
  always_comb begin
    elem_t lvl [N];
    for (int i = 0; i < N; i++) begin
      lvl[i] = sum_in[i];
    end
    for (int s = N / 2; s >= 1; s = s / 2) begin
      for (int i = 0; i < s; i++) begin
        lvl[i] = lvl[2*i] + lvl[2*i+1];
      end
    end
    dot = lvl[0];
  end

endmodule

// File: rtl/matrix_multiply_32.sv
// Streaming 32x32 matrix-multiply engine: one column per cycle, one result row per strobe.
// Define PIPELINE_EN to register the lane products (latency 2 instead of 1).
module matrix_multiply_32
  import matmul32_pkg::*;
(
  input logic                clk,
  input logic                reset,
  matrix_multiply_32_if.slave bus
);

  row_t          prod_s;
  row_t          sum_in_s;
  elem_t         dot_s;
  logic [IW-1:0] stage_idx_a_s;
  logic [IW-1:0] stage_idx_b_s;
  logic          stage_sel_s;
  row_t          row_buf_r;
  row_t          next_row_s;

  dot32 u_dot (
    .a      (bus.A_wire),
    .b      (bus.B_wire),
    .prod   (prod_s),
    .sum_in (sum_in_s),
    .dot    (dot_s)
  );

`ifdef PIPELINE_EN
  row_t          prod_r;
  logic [IW-1:0] idx_a_r;
  logic [IW-1:0] idx_b_r;
  logic          sel_r;

  // Product stage: indices and tag travel with the products they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_r  <= '0;
      idx_a_r <= 5'd0;
      idx_b_r <= 5'd0;
      sel_r   <= 1'b0;
    end else begin
      prod_r  <= prod_s;
      idx_a_r <= bus.index_A;
      idx_b_r <= bus.index_B;
      sel_r   <= bus.select_line_in;
    end
  end

  assign sum_in_s      = prod_r;
  assign stage_idx_a_s = idx_a_r;
  assign stage_idx_b_s = idx_b_r;
  assign stage_sel_s   = sel_r;
`else
  assign sum_in_s      = prod_s;
  assign stage_idx_a_s = bus.index_A;
  assign stage_idx_b_s = bus.index_B;
  assign stage_sel_s   = bus.select_line_in;
`endif

  // Completed row: the last column bypasses row_buf since it lands on the same edge.
  always_comb begin
    next_row_s        = row_buf_r;
    next_row_s[N-1]   = dot_s;
  end

  // Row assembly; unsupplied columns simply keep whatever they held before.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_buf_r <= '0;
    end else begin
      row_buf_r[stage_idx_b_s] <= dot_s;
    end
  end

  // Output registers and one-cycle write strobe on the last column.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.out             <= '0;
      bus.out_address     <= 5'd0;
      bus.select_line_out <= 1'b0;
      bus.write_data      <= 1'b0;
    end else if (stage_idx_b_s == LAST_IDX) begin
      bus.out             <= next_row_s;
      bus.out_address     <= stage_idx_a_s;
      bus.select_line_out <= stage_sel_s;
      bus.write_data      <= 1'b1;
    end else begin
      bus.write_data      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matrix_multiply_32.sv
// Directed bench for matrix_multiply_32; honours PIPELINE_EN by shifting the expected latency.
module tb_matrix_multiply_32;
  import matmul32_pkg::*;

`ifdef PIPELINE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  matrix_multiply_32_if bus ();

  matrix_multiply_32 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          wd;
    logic [IW-1:0] addr;
    logic          sel;
    row_t          row;
  } snap_t;

  typedef struct {
    row_t          a;
    row_t          b;
    logic [IW-1:0] ia;
    logic          sel;
    elem_t         exp;
  } vec_t;

  snap_t hist[$];
  vec_t  tbl[8];
  int    total = 0;
  int    bad   = 0;

  function automatic row_t fill(input elem_t v);
    row_t r;
    for (int e = 0; e < N; e++) r[e] = v;
    return r;
  endfunction

  function automatic row_t unit(input int j, input elem_t v);
    row_t r;
    r = '0;
    r[j] = v;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input row_t a, input row_t b, input logic [IW-1:0] ia,
                      input logic [IW-1:0] ib, input logic sel);
    snap_t s;
    bus.A_wire         = a;
    bus.B_wire         = b;
    bus.index_A        = ia;
    bus.index_B        = ib;
    bus.select_line_in = sel;
    @(posedge clk);
    #1;
    s.wd   = bus.write_data;
    s.addr = bus.out_address;
    s.sel  = bus.select_line_out;
    s.row  = bus.out;
    hist.push_back(s);
  endtask

  task automatic idle();
    step('0, '0, 5'd0, 5'd0, 1'b0);
  endtask

  function automatic int pulses_from(input int h0);
    int n;
    n = 0;
    for (int i = h0; i < hist.size(); i++) n += int'(hist[i].wd);
    return n;
  endfunction

  initial begin
    int    h0;
    snap_t s;
    row_t  ta;
    row_t  cb;

    tbl[0] = '{fill(32'd1), fill(32'd1), 5'd0, 1'b1, 32'd32};
    tbl[1].a = '0; tbl[1].a[0] = 32'hFFFF_FFFD; tbl[1].a[1] = 32'd2;
    tbl[1].b = '0; tbl[1].b[0] = 32'd7;         tbl[1].b[1] = 32'd4;
    tbl[1].ia = 5'd1; tbl[1].sel = 1'b0; tbl[1].exp = 32'hFFFF_FFF3;
    tbl[2] = '{unit(0, 32'hFFFF_FFFF), unit(0, 32'hFFFF_FFFF), 5'd2, 1'b1, 32'd1};
    for (int e = 0; e < N; e++) ta[e] = 32'(e);
    tbl[3] = '{ta, fill(32'd1), 5'd3, 1'b0, 32'd496};
    tbl[4] = '{fill(32'd2), fill(32'd3), 5'd4, 1'b1, 32'd192};
    tbl[5] = '{unit(0, 32'h0001_0000), unit(0, 32'h0001_0000), 5'd5, 1'b0, 32'd0};
    tbl[6] = '{unit(5, 32'h8000_0000), unit(5, 32'd3), 5'd6, 1'b1, 32'h8000_0000};
    tbl[7] = '{unit(31, 32'd100), unit(31, 32'hFFFF_FFFF), 5'd31, 1'b1, 32'hFFFF_FF9C};

    // reset state
    bus.A_wire = '0; bus.B_wire = '0; bus.index_A = 5'd0; bus.index_B = 5'd0;
    bus.select_line_in = 1'b0;
    #12;
    chk("rst_wd", 32'(bus.write_data), 32'd0);
    chk("rst_addr", 32'(bus.out_address), 32'd0);
    chk("rst_sel", 32'(bus.select_line_out), 32'd0);
    chk("rst_out31", bus.out[31], 32'd0);
    reset = 1'b1;

    // single-column dot products, each completing a row
    for (int v = 0; v < 8; v++) begin
      h0 = hist.size();
      step(tbl[v].a, tbl[v].b, tbl[v].ia, LAST_IDX, tbl[v].sel);
      idle();
      s = hist[h0+LAT-1];
      chk($sformatf("vec%0d_wd", v), 32'(s.wd), 32'd1);
      chk($sformatf("vec%0d_addr", v), 32'(s.addr), 32'(tbl[v].ia));
      chk($sformatf("vec%0d_sel", v), 32'(s.sel), 32'(tbl[v].sel));
      chk($sformatf("vec%0d_dot", v), s.row[31], tbl[v].exp);
    end

    // all-ones full row
    h0 = hist.size();
    for (int k = 0; k < N; k++) step(fill(32'd1), fill(32'd1), 5'd5, 5'(k), 1'b1);
    idle();
    chk("ones_pulses", 32'(pulses_from(h0)), 32'd1);
    s = hist[h0+N-1+LAT-1];
    chk("ones_addr", 32'(s.addr), 32'd5);
    chk("ones_sel", 32'(s.sel), 32'd1);
    for (int j = 0; j < N; j++) chk($sformatf("ones_e%0d", j), s.row[j], 32'd32);

    // identity row 7
    h0 = hist.size();
    for (int k = 0; k < N; k++) step(unit(7, 32'd1), unit(k, 32'd1), 5'd7, 5'(k), 1'b0);
    idle();
    s = hist[h0+N-1+LAT-1];
    chk("ident_wd", 32'(s.wd), 32'd1);
    chk("ident_addr", 32'(s.addr), 32'd7);
    chk("ident_sel", 32'(s.sel), 32'd0);
    for (int j = 0; j < N; j++) chk($sformatf("ident_e%0d", j), s.row[j], (j == 7) ? 32'd1 : 32'd0);

    // wrap across a full row
    h0 = hist.size();
    for (int k = 0; k < N; k++)
      step(unit(0, 32'hFFFF_FFFF), unit(0, 32'hFFFF_FFFF), 5'd12, 5'(k), 1'b1);
    idle();
    s = hist[h0+N-1+LAT-1];
    chk("wrap_addr", 32'(s.addr), 32'd12);
    for (int j = 0; j < N; j++) chk($sformatf("wrap_e%0d", j), s.row[j], 32'd1);

    // streaming diagonal: element j = j*(j+1)
    h0 = hist.size();
    for (int k = 0; k < N; k++) begin
      cb = unit(0, 32'(k));
      step(fill(32'(k + 1)), cb, 5'(k), 5'(k), 1'b0);
    end
    idle();
    chk("stream_pulses", 32'(pulses_from(h0)), 32'd1);
    s = hist[h0+N-1+LAT-1];
    chk("stream_wd", 32'(s.wd), 32'd1);
    chk("stream_addr", 32'(s.addr), 32'd31);
    for (int j = 0; j < N; j++) chk($sformatf("stream_e%0d", j), s.row[j], 32'(j * (j + 1)));

    // back-to-back completions
    h0 = hist.size();
    step(fill(32'd1), fill(32'd1), 5'd3, LAST_IDX, 1'b0);
    step(fill(32'd2), fill(32'd3), 5'd9, LAST_IDX, 1'b1);
    idle();
    chk("b2b_pulses", 32'(pulses_from(h0)), 32'd2);
    s = hist[h0+LAT-1];
    chk("b2b0_wd", 32'(s.wd), 32'd1);
    chk("b2b0_addr", 32'(s.addr), 32'd3);
    chk("b2b0_dot", s.row[31], 32'd32);
    s = hist[h0+LAT];
    chk("b2b1_wd", 32'(s.wd), 32'd1);
    chk("b2b1_addr", 32'(s.addr), 32'd9);
    chk("b2b1_sel", 32'(s.sel), 32'd1);
    chk("b2b1_dot", s.row[31], 32'd192);

    // reset mid-row discards the partial row
    for (int k = 0; k < 10; k++) step(fill(32'd1), fill(32'd1), 5'd4, 5'(k), 1'b1);
    #2;
    reset = 1'b0;
    #2;
    chk("mid_rst_wd", 32'(bus.write_data), 32'd0);
    chk("mid_rst_addr", 32'(bus.out_address), 32'd0);
    chk("mid_rst_sel", 32'(bus.select_line_out), 32'd0);
    chk("mid_rst_out31", bus.out[31], 32'd0);
    chk("mid_rst_out30", bus.out[30], 32'd0);
    #2;
    reset = 1'b1;
    h0 = hist.size();
    for (int k = 10; k < N - 1; k++) step(fill(32'd1), fill(32'd1), 5'd4, 5'(k), 1'b1);
    step(fill(32'd1), fill(32'd1), 5'd6, LAST_IDX, 1'b0);
    idle();
    chk("post_rst_pulses", 32'(pulses_from(h0)), 32'd1);
    s = hist[h0+(N-11)+LAT-1];
    chk("post_rst_wd", 32'(s.wd), 32'd1);
    chk("post_rst_addr", 32'(s.addr), 32'd6);
    for (int j = 0; j < N; j++)
      chk($sformatf("post_rst_e%0d", j), s.row[j], (j >= 10) ? 32'd32 : 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
